jtag_scan_loader: RTL and testbench
===================================

// Module: jtag_scan_loader
// PURPOSE
//  Upstream driver of the 512-word JTAG-loadable data/instruction RAM scan chain.
//  Accepts a stream of 32-bit image words from the host/debug port and shifts them into the chain via Jen/Jin.
//  Simultaneously captures the words falling out of Jout, giving a full-memory readback/dump.
//  busy stalls the CPU and masks RAM Wen for the whole session.
// PARAMETERS
//  DEPTH   512  chain length in words; one session = exactly DEPTH shifts
//  CNT_W   10   counter width, = $clog2(DEPTH)+1
//  CAPTURE 1    1: Jout words are returned on out_*; 0: out_valid tied 0, out_ready ignored
// PORTS
//  clk        in   1      system clock; all state changes on its rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  start      in   1      one-cycle request to begin a session; ignored while busy
//  abort      in   1      terminate session at next edge; done is not pulsed
//  in_valid   in   1      host word available
//  in_ready   out  1      host word consumed this cycle (equals jen)
//  in_data    in   32     host word
//  out_valid  out  1      captured chain word available
//  out_ready  in   1      consumer takes out_data this cycle
//  out_data   out  32     captured chain word
//  jen        out  1      to RAM Jen: chain shifts one word on this edge
//  jin        out  32     to RAM Jin; equals in_data
//  jout       in   32     from RAM Jout: word at the chain's far end
//  busy       out  1      session active (SHIFT or DRAIN)
//  done       out  1      one-cycle pulse on normal completion
//  count      out  CNT_W  shifts performed in current/last session
// BEHAVIOUR
//  Reset values: state IDLE, in_ready=0, jen=0, out_valid=0, out_data=0, busy=0, done=0, count=0.
//  FSM: IDLE -start-> SHIFT; SHIFT -last shift-> DRAIN; DRAIN -out reg empty-> DONE; DONE -> IDLE (1 cycle).
//  In IDLE: start also clears count to 0. jen=0 outside SHIFT.
//  fire = (state==SHIFT) & in_valid & (!out_valid | out_ready | !CAPTURE). Combinational.
//  jen = in_ready = fire; jin = in_data unconditionally.
//  On a fire edge: count+=1; if CAPTURE, out_data<=jout (pre-shift value), out_valid<=1.
//  Otherwise, out_valid clears on out_valid & out_ready.
//  Throughput: one word per cycle with in_valid=1 and out_ready=1. Capture latency: out_valid rises 1 cycle after the fire.
//  Last shift: fire with count==DEPTH-1. Next state is DRAIN; count then reads DEPTH.
//  DRAIN: no jen. Leave DRAIN once out_valid==0 or out_ready==1 (immediately if CAPTURE=0).
//  Ordering: first word shifted in ends at the Jout end of the chain.
//   The host sends the highest chain position first; readback emerges in the same order.
//  Simultaneous events:
//   - abort beats everything, including a pending fire and start in the same cycle.
//     Abort -> IDLE, out_valid<=0, no done; count holds its value.
//   - start while busy is ignored.
//   - start and abort together in IDLE -> stay IDLE.
//  Reset mid-session: immediate return to reset values. RAM contents are partially shifted (undefined image).
//  busy=1 in SHIFT and DRAIN. done=1 only in the DONE cycle.
// STRUCTURE
//  Shared package jtag_pkg: WORD_W=32, RAM_DEPTH=512, state enum {IDLE,SHIFT,DRAIN,DONE}.
//  Single module, no sub-modules: FSM + counter + one-entry output register.
// TESTING
//  1. Full load: start, in_valid=1, in_data=32'h1000_0000+i for i=0..511, out_ready=1.
//     -> 512 jen cycles back-to-back; count=512; one done pulse.
//     RAM readback via Dout: position p holds h1000_0000+(511-p).
//  2. Dump: preload RAM with Din=addr*4, then run a session feeding zeros.
//     -> out_data stream equals RAM contents in far-end-first order; RAM all zero afterwards.
//  3. Backpressure: out_ready low for 5 cycles at word 100.
//     -> jen=0 while out_valid=1 and out_ready=0; no word lost or duplicated; count continues to 512.
//  4. Host gaps: in_valid toggles 1/0. -> jen only on valid cycles; session ends after exactly 512 fires.
//  5. Abort at count=200: assert abort. -> next cycle IDLE, busy=0, out_valid=0, no done, count=200.
//     A subsequent start restarts count at 0.
//  6. Reset asserted at count=37 asynchronously. -> outputs at reset values before the next clk edge.
//     start while busy (count=10) has no effect on count or state.

Source files
------------

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared widths, chain depth and loader FSM state codes.
package jtag_pkg;
    localparam int WORD_W    = 32;
    localparam int RAM_DEPTH = 512;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t SHIFT = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t DONE  = 2'd3;
endpackage

// File: rtl/jtag_scan_loader.sv
// jtag_scan_loader: streams host words into the RAM scan chain and returns the words shifted out.
module jtag_scan_loader
    import jtag_pkg::*;
#(
    parameter int DEPTH   = RAM_DEPTH,
    parameter int CNT_W   = $clog2(DEPTH) + 1,
    parameter bit CAPTURE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              jen,
    output logic [WORD_W-1:0] jin,
    input  logic [WORD_W-1:0] jout,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count
);
    state_t state;
    logic   slot_free;
    logic   fire;
    logic   last;
    // A shift is only allowed when the word falling out of the chain has somewhere to go.
    assign slot_free = !out_valid || out_ready || !CAPTURE;
    assign fire      = (state == SHIFT) && in_valid && slot_free && !abort;
    assign last      = count == CNT_W'(DEPTH - 1);
    assign jen       = fire;
    assign in_ready  = fire;
    assign jin       = in_data;
    assign busy      = (state == SHIFT) || (state == DRAIN);
    assign done      = state == DONE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) begin
                    state <= SHIFT;
                    count <= '0;
                end
                SHIFT:   if (fire) begin
                    count <= count + 1'b1;
                    state <= last ? DRAIN : SHIFT;
                end
                DRAIN:   state <= slot_free ? DONE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
    generate
        if (CAPTURE) begin : g_capture
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else if (abort) begin
                    out_valid <= 1'b0;
                end else if (fire) begin
                    out_valid <= 1'b1;
                    out_data  <= jout;
                end else if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end else begin : g_no_capture
            assign out_valid = 1'b0;
            assign out_data  = '0;
        end
    endgenerate
endmodule

// File: tb/tb_jtag_scan_loader.sv
// tb_jtag_scan_loader: randomized sessions against a queue-based chain and loader reference model.
module tb_jtag_scan_loader;
    localparam int DEPTH = 512;
    logic        clk = 1'b0;
    logic        reset, start, abort, in_valid, out_ready;
    logic [31:0] in_data, jout;
    logic        in_ready, out_valid, jen, busy, done;
    logic [31:0] out_data, jin;
    logic [9:0]  count;
    jtag_scan_loader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .jen(jen), .jin(jin), .jout(jout),
        .busy(busy), .done(done), .count(count)
    );
    always #5 clk = ~clk;
    logic [31:0] chain[$];
    logic [31:0] m_slot[$];
    logic [31:0] dumped[$];
    bit          m_active, m_fin, exp_jen;
    int          m_shifted;
    int          checks = 0, errors = 0, jen_cnt = 0, done_cnt = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic model_clear();
        m_active = 0;
        m_fin = 0;
        m_shifted = 0;
        m_slot.delete();
    endtask
    // One clock: drive jout, compare every output with the model, then advance chain and model.
    task automatic step();
        logic        jen_s;
        logic [31:0] jin_s, jout_s;
        bit          empty_before, was_fin, full_before;
        @(negedge clk);
        jout = chain[0];
        #1;
        exp_jen = !reset && m_active && m_shifted < DEPTH && in_valid && !abort &&
                  (m_slot.size() == 0 || out_ready);
        chk("jen", jen, exp_jen);
        chk("in_ready", in_ready, exp_jen);
        chk("jin", jin, in_data);
        chk("busy", busy, m_active);
        chk("done", done, m_fin);
        chk("count", count, m_shifted);
        chk("out_valid", out_valid, m_slot.size() != 0);
        if (m_slot.size() != 0) chk("out_data", out_data, m_slot[0]);
        jen_s = jen;
        jin_s = jin;
        jout_s = jout;
        if (jen) jen_cnt++;
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        if (jen_s) begin
            void'(chain.pop_front());
            chain.push_back(jin_s);
        end
        if (reset) begin
            model_clear();
        end else begin
            empty_before = m_slot.size() == 0;
            if (!empty_before && out_ready) dumped.push_back(m_slot.pop_front());
            if (abort) begin
                m_active = 0;
                m_fin = 0;
                m_slot.delete();
            end else begin
                was_fin = m_fin;
                m_fin = 0;
                if (m_active) begin
                    full_before = m_shifted == DEPTH;
                    if (exp_jen) begin
                        m_slot.push_back(jout_s);
                        m_shifted++;
                    end
                    if (full_before && (empty_before || out_ready)) begin
                        m_active = 0;
                        m_fin = 1;
                    end
                end else if (!was_fin && start) begin
                    m_active = 1;
                    m_shifted = 0;
                end
            end
        end
    endtask
    task automatic idle(input int n);
        start = 0; abort = 0; in_valid = 0; out_ready = 1;
        for (int i = 0; i < n; i++) step();
    endtask
    // mode 0 full load, 1 dump, 2 backpressure at word 100, 3 host gaps, 4 random
    task automatic session(input int mode, input int abort_at, input int restart_at, input int reset_at);
        int bp = 0;
        bit hit = 0;
        bit ab;
        start = 1; abort = 0; in_valid = 0; out_ready = 1;
        step();
        start = 0;
        for (int c = 0; c < 4000; c++) begin
            case (mode)
                0: begin in_valid = 1; out_ready = 1; in_data = 32'h1000_0000 + m_shifted; end
                1: begin in_valid = 1; out_ready = $urandom % 2; in_data = 0; end
                2: begin
                    if (m_shifted == 100 && !hit) begin hit = 1; bp = 5; end
                    in_valid = 1; out_ready = bp == 0; in_data = $urandom;
                    if (bp > 0) bp--;
                end
                3: begin in_valid = c % 2 == 0; out_ready = 1; in_data = $urandom; end
                default: begin
                    in_valid = $urandom % 4 != 0; out_ready = $urandom % 3 != 0; in_data = $urandom;
                end
            endcase
            abort = abort_at >= 0 && m_active && m_shifted == abort_at;
            start = restart_at >= 0 && m_active && m_shifted == restart_at;
            step();
            ab = abort;
            abort = 0;
            start = 0;
            if (reset_at >= 0 && m_active && m_shifted == reset_at) begin
                #1 reset = 1;
                model_clear();
                #1;
                chk("async_rst_busy", busy, 0);
                chk("async_rst_count", count, 0);
                chk("async_rst_jen", jen, 0);
                chk("async_rst_in_ready", in_ready, 0);
                chk("async_rst_out_valid", out_valid, 0);
                chk("async_rst_out_data", out_data, 0);
                chk("async_rst_done", done, 0);
                step();
                reset = 0;
                return;
            end
            if (ab || m_fin) return;
        end
        chk("session_timeout", 1, 0);
    endtask
    task automatic full_check(input string name);
        chk({name, "_jen_cnt"}, jen_cnt, 512);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_count"}, count, 512);
    endtask
    initial begin
        int bad;
        reset = 1; start = 0; abort = 0; in_valid = 0; out_ready = 0; in_data = 0;
        for (int k = 0; k < DEPTH; k++) chain.push_back($urandom);
        model_clear();
        step(); step();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_jen", jen, 0);
        chk("rst_done", done, 0);
        reset = 0;
        idle(2);
        jen_cnt = 0; done_cnt = 0;
        session(0, -1, -1, -1);
        idle(3);
        full_check("load");
        chk("load_far_end", chain[0], 32'h1000_0000);
        chk("load_near_end", chain[511], 32'h1000_01FF);
        for (int k = 0; k < DEPTH; k++) chain[k] = k * 4;
        dumped.delete();
        session(1, -1, -1, -1);
        idle(3);
        chk("dump_size", dumped.size(), 512);
        bad = 0;
        for (int k = 0; k < dumped.size(); k++) if (dumped[k] !== k * 4) bad++;
        chk("dump_order", bad, 0);
        chk("dump_word100", dumped[100], 32'd400);
        bad = 0;
        foreach (chain[k]) if (chain[k] !== 0) bad++;
        chk("dump_ram_zero", bad, 0);
        jen_cnt = 0; done_cnt = 0;
        session(2, -1, -1, -1);
        idle(3);
        full_check("bp");
        jen_cnt = 0; done_cnt = 0;
        session(3, -1, -1, -1);
        idle(3);
        full_check("gaps");
        done_cnt = 0;
        session(4, 200, -1, -1);
        idle(2);
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_count", count, 200);
        chk("abort_done", done_cnt, 0);
        start = 1;
        step();
        start = 0;
        chk("restart_count", count, 0);
        chk("restart_busy", busy, 1);
        abort = 1;
        step();
        abort = 0;
        idle(2);
        jen_cnt = 0; done_cnt = 0;
        session(4, -1, -1, -1);
        idle(3);
        full_check("random");
        session(4, -1, 10, 37);
        idle(3);
        jen_cnt = 0; done_cnt = 0;
        session(4, -1, 10, -1);
        idle(3);
        full_check("after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
